// File: rtl/uart_file_pkg.sv
// Shared types and constants for the UART file loader.
//   state_e    : loader FSM states
//   mem_word_t : packed write payload (byte strobes + 32-bit word)
//   *_CHAR     : protocol characters exchanged with the host
package uart_file_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned STRB_W = WORD_W / 8;

    localparam logic [7:0] REQ_CHAR     = 8'h02;
    localparam logic [7:0] HOST_RX_CHAR = 8'h03;
    localparam logic [7:0] FINISH_CHAR  = 8'h04;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        SIZE  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_e;

    typedef struct packed {
        logic [STRB_W-1:0] wstrb;
        logic [WORD_W-1:0] wdata;
    } mem_word_t;

endpackage

// File: rtl/uart_file_loader_if.sv
// Byte-TX, byte-RX and memory-write handshakes of the UART file loader.
//   master : loader side (drives tx_*, rx_ready, mem_* requests)
//   slave  : UART / memory side
interface uart_file_loader_if #(
    parameter int unsigned MEM_ADDR_W = 16
) ();
    logic                  tx_valid;
    logic                  tx_ready;
    logic [7:0]            tx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [7:0]            rx_data;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wstrb;

    modport master (
        output tx_valid, tx_data,   input  tx_ready,
        input  rx_valid, rx_data,   output rx_ready,
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready
    );

    modport slave (
        input  tx_valid, tx_data,   output tx_ready,
        output rx_valid, rx_data,   input  rx_ready,
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready
    );
endinterface

// File: rtl/uart_file_word_packer.sv
// Byte-lane buffer that assembles received bytes into a little-endian word.
//   clk, rst_n : clock, async active-low reset
//   wr_en      : write din into lane and set its strobe
//   clr        : zero the buffer and strobes (takes priority over wr_en)
//   lane       : byte lane 0..3
//   din        : byte to store
//   word       : registered word + accumulated strobes
module uart_file_word_packer
    import uart_file_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      wr_en,
    input  logic      clr,
    input  logic [1:0] lane,
    input  logic [7:0] din,
    output mem_word_t word
);

    mem_word_t word_q, word_d;

    // Clearing zeroes the data too, so unfilled lanes of a partial word read 0.
    always_comb begin
        word_d = word_q;
        if (clr) begin
            word_d = '0;
        end else if (wr_en) begin
            word_d.wdata[{lane, 3'b000} +: 8] = din;
            word_d.wstrb[lane]                = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word = word_q;

endmodule

// File: rtl/uart_file_loader.sv
// Device-side receiver of the host "send file" command: sends the request
// char, reads a 4-byte LE size, then packs file bytes into 32-bit words and
// writes them to a word-addressed memory port.
//   clk, rst_n : clock, async active-low reset
//   start      : pulse, begins a transfer when idle
//   base_addr  : word address of first write, sampled on start
//   bus        : tx / rx / mem handshakes (master side)
//   busy       : transfer in progress
//   done       : one-cycle pulse at end of transfer
//   error      : size exceeded MAX_BYTES, held until next start
//   file_size  : received size, held after done
module uart_file_loader #(
    parameter int unsigned MEM_ADDR_W = 16,
    parameter int unsigned MAX_BYTES  = 65536,
    parameter logic [7:0]  REQ_CHAR   = uart_file_pkg::REQ_CHAR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [MEM_ADDR_W-1:0] base_addr,
    uart_file_loader_if.master    bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           file_size
);
    import uart_file_pkg::*;

    localparam int unsigned CNT_W = 32;

    state_e                state_q, state_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  mem_valid_q, mem_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [CNT_W-1:0]      size_q, size_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;

    logic                  tx_fire_c, rx_fire_c, mem_fire_c;
    logic                  pk_wr_c, pk_clr_c;
    logic [CNT_W-1:0]      size_full_c;
    mem_word_t             pk_word;

    uart_file_word_packer u_packer (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (pk_wr_c),
        .clr   (pk_clr_c),
        .lane  (cnt_q[1:0]),
        .din   (bus.rx_data),
        .word  (pk_word)
    );

    // Next-state, counters and registered outputs.
    always_comb begin
        state_d     = state_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        rx_ready_d  = rx_ready_q;
        mem_valid_d = mem_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        size_d      = size_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        pk_wr_c     = 1'b0;
        pk_clr_c    = 1'b0;

        tx_fire_c   = tx_valid_q & bus.tx_ready;
        rx_fire_c   = rx_ready_q & bus.rx_valid;
        mem_fire_c  = mem_valid_q & bus.mem_ready;
        // Size as it will be once the byte on rx_data lands in the top lane.
        size_full_c = {bus.rx_data, size_q[23:0]};

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = REQ;
                    tx_valid_d = 1'b1;
                    tx_data_d  = REQ_CHAR;
                    busy_d     = 1'b1;
                    error_d    = 1'b0;
                    size_d     = '0;
                    cnt_d      = '0;
                    addr_d     = base_addr;
                    pk_clr_c   = 1'b1;
                end
            end
            REQ: begin
                if (tx_fire_c) begin
                    state_d    = SIZE;
                    tx_valid_d = 1'b0;
                    rx_ready_d = 1'b1;
                end
            end
            SIZE: begin
                if (rx_fire_c) begin
                    size_d[{cnt_q[1:0], 3'b000} +: 8] = bus.rx_data;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q[1:0] == 2'd3) begin
                        cnt_d = '0;
                        if (size_full_c == '0) begin
                            state_d    = DONE;
                            rx_ready_d = 1'b0;
                            done_d     = 1'b1;
                            busy_d     = 1'b0;
                        end else if (size_full_c > CNT_W'(MAX_BYTES)) begin
                            // Leftover host bytes are deliberately not drained.
                            state_d    = DONE;
                            rx_ready_d = 1'b0;
                            done_d     = 1'b1;
                            busy_d     = 1'b0;
                            error_d    = 1'b1;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (rx_fire_c) begin
                    pk_wr_c = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q[1:0] == 2'd3 || (cnt_q + CNT_W'(1)) == size_q) begin
                        state_d     = WRITE;
                        rx_ready_d  = 1'b0;
                        mem_valid_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (mem_fire_c) begin
                    pk_clr_c    = 1'b1;
                    mem_valid_d = 1'b0;
                    addr_d      = addr_q + MEM_ADDR_W'(1);
                    if (cnt_q == size_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d    = DATA;
                        rx_ready_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            rx_ready_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            size_q      <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            rx_ready_q  <= rx_ready_d;
            mem_valid_q <= mem_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            size_q      <= size_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
        end
    end

    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.rx_ready  = rx_ready_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = pk_word.wdata;
    assign bus.mem_wstrb = pk_word.wstrb;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign file_size     = size_q;

endmodule

// File: tb/tb_uart_file_loader.sv
// Scoreboard bench for uart_file_loader: directed transfers push expected
// tx bytes, memory writes and done results; a negedge monitor pops and
// compares them whenever the DUT completes a handshake or pulses done.
module tb_uart_file_loader;

    localparam int unsigned AW = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          busy;
    logic          done;
    logic          error;
    logic [31:0]   file_size;

    uart_file_loader_if #(.MEM_ADDR_W(AW)) bus ();

    uart_file_loader #(
        .MEM_ADDR_W (AW),
        .MAX_BYTES  (65536),
        .REQ_CHAR   (8'h02)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .file_size (file_size)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    strb;
    } wr_t;

    typedef struct {
        logic        err;
        logic [31:0] size;
    } done_t;

    logic [7:0] tx_q[$];
    wr_t        wr_q[$];
    done_t      done_q[$];
    logic [7:0] xfer_bytes[$];

    int   n_tests = 0;
    int   n_fail  = 0;
    logic mv_at_accept;
    wr_t   mon_w;
    done_t mon_d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // Monitor: compare every completed handshake / done pulse against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.tx_valid && bus.tx_ready) begin
                if (tx_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL tx_unexpected: got %h, none expected", bus.tx_data);
                end else begin
                    check("tx_data", 64'(bus.tx_data), 64'(tx_q.pop_front()));
                end
            end
            if (bus.mem_valid && bus.mem_ready) begin
                if (wr_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL mem_unexpected: got addr %h data %h strb %h, none expected",
                             bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
                end else begin
                    mon_w = wr_q.pop_front();
                    check("mem_addr",  64'(bus.mem_addr),  64'(mon_w.addr));
                    check("mem_wdata", 64'(bus.mem_wdata), 64'(mon_w.data));
                    check("mem_wstrb", 64'(bus.mem_wstrb), 64'(mon_w.strb));
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL done_unexpected: got done with size %h", file_size);
                end else begin
                    mon_d = done_q.pop_front();
                    check("done_error", 64'(error),     64'(mon_d.err));
                    check("done_size",  64'(file_size), 64'(mon_d.size));
                end
            end
        end
    end

    task automatic do_start(input logic [AW-1:0] b);
        start     = 1'b1;
        base_addr = b;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_tx();
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(bus.tx_valid && bus.tx_ready) && n < 100);
        if (!(bus.tx_valid && bus.tx_ready)) timeout("wait_tx");
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        do begin @(negedge clk); n++; end
        while (!bus.rx_ready && n < 200);
        if (!bus.rx_ready) timeout("send_byte");
        mv_at_accept = bus.mem_valid;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic gap(input bit en);
        if (en) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    endtask

    task automatic send_size(input logic [31:0] sz, input bit gaps);
        for (int k = 0; k < 4; k++) begin
            gap(gaps);
            send_byte(sz[8*k +: 8]);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!done && n < 200);
        if (!done) timeout("wait_done");
        @(posedge clk); #1;
    endtask

    task automatic run_xfer(input logic [AW-1:0] b, input logic [31:0] sz, input bit gaps);
        if (gaps) bus.tx_ready = 1'b0;
        do_start(b);
        check("busy_after_start", 64'(busy), 64'(1));
        if (gaps) begin
            repeat ($urandom_range(1, 6)) begin @(posedge clk); #1; end
            bus.tx_ready = 1'b1;
        end
        wait_tx();
        send_size(sz, gaps);
        for (int i = 0; i < xfer_bytes.size(); i++) begin
            gap(gaps);
            send_byte(xfer_bytes[i]);
        end
        wait_done();
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_t w;
        w.addr = a; w.data = d; w.strb = s;
        wr_q.push_back(w);
    endtask

    task automatic push_done(input logic e, input logic [31:0] s);
        done_t d;
        d.err = e; d.size = s;
        done_q.push_back(d);
    endtask

    task automatic push_8byte(input logic [AW-1:0] b);
        tx_q.push_back(8'h02);
        push_wr(b,        32'h03020100, 4'hF);
        push_wr(b + 16'h1, 32'h07060504, 4'hF);
        push_done(1'b0, 32'd8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        base_addr     = '0;
        bus.tx_ready  = 1'b1;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = '0;
        bus.mem_ready = 1'b1;

        // Reset values
        #12;
        check("reset_ctrl", 64'({bus.tx_valid, bus.tx_data, bus.rx_ready, bus.mem_valid,
                                 bus.mem_addr, bus.mem_wstrb, busy, done, error}), 64'(0));
        check("reset_data", {bus.mem_wdata, file_size}, 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 8 bytes 00..07 at 0x10
        push_8byte(16'h0010);
        xfer_bytes = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        run_xfer(16'h0010, 32'd8, 1'b0);
        check("a_file_size", 64'(file_size), 64'(8));
        check("a_busy_idle", 64'(busy), 64'(0));

        // 5 bytes, partial last word, latency and start-while-busy
        tx_q.push_back(8'h02);
        push_wr(16'h0050, 32'hDDCCBBAA, 4'hF);
        push_wr(16'h0051, 32'h000000EE, 4'h1);
        push_done(1'b0, 32'd5);
        do_start(16'h0050);
        wait_tx();
        send_size(32'd5, 1'b0);
        do_start(16'h0099);
        check("b_busy_ignore_start", 64'(busy), 64'(1));
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        check("b_lat_word0", 64'({mv_at_accept, bus.mem_valid}), 64'(2'b01));
        send_byte(8'hEE);
        check("b_lat_last", 64'({mv_at_accept, bus.mem_valid}), 64'(2'b01));
        wait_done();

        // Size 0: done right after the 4th size byte, no writes
        tx_q.push_back(8'h02);
        push_done(1'b0, 32'd0);
        do_start(16'h0060);
        wait_tx();
        send_size(32'd0, 1'b0);
        check("c_done_now", 64'({done, error, bus.mem_valid}), 64'(3'b100));
        wait_done();

        // Oversize 70000: error, no writes, stream not consumed
        tx_q.push_back(8'h02);
        push_done(1'b1, 32'd70000);
        do_start(16'h0070);
        wait_tx();
        send_size(32'd70000, 1'b0);
        check("d_done_err", 64'({done, error, bus.rx_ready}), 64'(3'b110));
        wait_done();
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("d_rx_ready_low", 64'(bus.rx_ready), 64'(0));
        end
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        check("d_err_held", 64'({error, file_size}), 64'({1'b1, 32'd70000}));

        // mem_ready low for 10 cycles during the first write
        tx_q.push_back(8'h02);
        push_wr(16'h0040, 32'h13121110, 4'hF);
        push_wr(16'h0041, 32'h17161514, 4'hF);
        push_done(1'b0, 32'd8);
        do_start(16'h0040);
        wait_tx();
        send_size(32'd8, 1'b0);
        send_byte(8'h10);
        send_byte(8'h11);
        send_byte(8'h12);
        bus.mem_ready = 1'b0;
        send_byte(8'h13);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h14;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("e_stall_hold", 64'({bus.mem_valid, bus.rx_ready, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata}),
                  64'({1'b1, 1'b0, 4'hF, 16'h0040, 32'h13121110}));
        end
        @(posedge clk); #1;
        bus.mem_ready = 1'b1;
        send_byte(8'h14);
        send_byte(8'h15);
        send_byte(8'h16);
        send_byte(8'h17);
        wait_done();

        // Random tx_ready / rx_valid gaps, same 8-byte image
        for (int r = 0; r < 2; r++) begin
            push_8byte(16'h0010);
            xfer_bytes = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
            run_xfer(16'h0010, 32'd8, 1'b1);
        end

        // Reset in the middle of DATA
        tx_q.push_back(8'h02);
        do_start(16'h0020);
        wait_tx();
        send_size(32'd8, 1'b0);
        send_byte(8'hA0);
        send_byte(8'hA1);
        #2;
        rst_n = 1'b0;
        #1;
        check("g_async_ctrl", 64'({bus.tx_valid, bus.tx_data, bus.rx_ready, bus.mem_valid,
                                   bus.mem_addr, bus.mem_wstrb, busy, done, error}), 64'(0));
        check("g_async_data", {bus.mem_wdata, file_size}, 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        tx_q.push_back(8'h02);
        push_wr(16'h0030, 32'h44332211, 4'hF);
        push_done(1'b0, 32'd4);
        xfer_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_xfer(16'h0030, 32'd4, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("end_tx_q_empty",   64'(tx_q.size()),   64'(0));
        check("end_wr_q_empty",   64'(wr_q.size()),   64'(0));
        check("end_done_q_empty", 64'(done_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_file_loader.md
Name: uart_file_loader

Overview:
- Device-side end of the UART file-transfer protocol, i.e. the receiver for the host's "send file" command.
- On start it emits request char 0x02 on the byte-TX stream. It then collects a 4-byte little-endian file size and the file bytes from the byte-RX stream.
- Bytes are packed little-endian into 32-bit words and written to a word-addressed memory port (main RAM / DDR bridge).
- It sits between the iob_uart byte interface and the system memory bus, so the CPU does not poll per byte.

Parameters:
- MEM_ADDR_W, 16, word-address width of memory port.
- MAX_BYTES, 65536, largest accepted file size in bytes; larger sizes are rejected.
- REQ_CHAR, 8'h02, request character sent to the host.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a transfer when idle
- base_addr  in  MEM_ADDR_W  word address of first write; sampled on start
- tx_valid  out  1  request char valid
- tx_ready  in  1  UART TX can accept a byte
- tx_data  out  8  byte to UART TX
- rx_valid  in  1  received byte valid
- rx_ready  out  1  loader accepts a byte this cycle
- rx_data  in  8  received byte
- mem_valid  out  1  memory write request
- mem_ready  in  1  memory accepted the write
- mem_addr  out  MEM_ADDR_W  word address
- mem_wdata  out  32  packed word, first received byte in [7:0]
- mem_wstrb  out  4  byte enables
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of transfer (success or error)
- error  out  1  size > MAX_BYTES; held until next start
- file_size  out  32  received size; held after done

Behaviour:
- Reset values: all outputs 0; state IDLE; internal byte counter 0.
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Handshakes: a transfer completes on a cycle with valid&ready. tx_valid/mem_valid, once raised, hold with stable data until accepted.
- IDLE:
  - start=1 → REQ; latch base_addr; clear error and file_size; busy=1 from the next cycle.
  - start while busy is ignored.
- REQ: tx_valid=1, tx_data=REQ_CHAR. On tx_ready → SIZE.
- SIZE:
  - rx_ready=1. Each accepted byte shifts into file_size; byte k goes to bits [8k+7:8k], k=0..3.
  - After the 4th byte:
    - size==0 → DONE.
    - size>MAX_BYTES → error=1, DONE. The remaining stream is not consumed; the host is responsible.
    - else → DATA.
- DATA:
  - rx_ready=1. Byte i goes to lane i mod 4 of the word buffer and sets that strobe bit.
  - When lane 3 fills, or the last byte (count==file_size) is accepted → WRITE.
  - The write is presented in the cycle after the accepting edge, so mem_valid rises 1 cycle after the byte handshake.
- WRITE:
  - rx_ready=0 (backpressure). mem_valid=1, mem_addr=base+word index, mem_wstrb=accumulated strobes (partial last word e.g. 4'b0011).
  - Unfilled lanes of mem_wdata are 0.
  - On mem_ready: word index +1, strobes cleared. Go to DONE if all bytes written, else DATA.
- DONE: done=1 for one cycle, busy=0 → IDLE.
- Counters:
  - Byte counter is 32-bit.
  - Word index is MEM_ADDR_W bits and wraps modulo 2^MEM_ADDR_W; no overflow check beyond MAX_BYTES.
- Simultaneous events:
  - rx_valid in REQ/WRITE/IDLE/DONE is not accepted (rx_ready=0).
  - start in the DONE cycle is ignored.
- Reset mid-transfer: immediate return to IDLE, all outputs 0, and no write in progress is completed.
  - Partial data already in memory is left as is.

Decomposition:
- Shared package (uart_file_pkg): state encoding (IDLE, REQ, SIZE, DATA, WRITE, DONE) and protocol chars REQ_CHAR=0x02, HOST_RX_CHAR=0x03, FINISH_CHAR=0x04.
- One natural sub-module: uart_file_word_packer (byte lane buffer + strobe accumulator + clear).
- FSM and counters stay in the top.

Test Plan:
- Size 8 bytes 00..07, base 0x10, mem_ready always 1:
  - tx 0x02 once.
  - Writes 0x10←0x03020100 wstrb F, then 0x11←0x07060504 wstrb F.
  - done pulse, file_size=8.
- Size 5 bytes AA BB CC DD EE:
  - Second write 0x000000EE wstrb 4'b0001.
  - Byte arrival to mem_valid latency exactly 1 cycle.
- Size 0: no mem_valid, done 1 cycle after 4th size byte, error=0.
- Size 70000 (> MAX_BYTES): error=1, done pulse, no writes, rx_ready low after the size.
- mem_ready held low 10 cycles during a write:
  - rx_ready stays 0, mem_addr/wdata stable, no byte lost.
  - Random tx_ready/rx_valid gaps give identical memory contents.
- rst_n asserted mid-DATA:
  - All outputs 0 asynchronously.
  - A new start then sends 0x02 and completes a 4-byte transfer correctly.
